// File: rtl/load_data_formatter.sv
// load_data_formatter: assembles 16-bit memory beats into a 32-bit load result
// with byte select and sign/zero extension, registered with a one-cycle valid pulse.
module load_data_formatter (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_start,
   input  logic [1:0]  word_type,
   input  logic        is_signed,
   input  logic        byte_offset,
   input  logic        flush,
   input  logic [15:0] mem_data_in,
   input  logic        mem_data_valid,
   output logic        busy,
   output logic        result_valid,
   output logic [31:0] result,
   output logic        type_error
);
   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
   localparam logic [1:0] WT_BYTE = 2'b00, WT_HALF = 2'b01, WT_WORD = 2'b10, WT_RSVD = 2'b11;
   state_t      state_q;
   logic [1:0]  type_q;
   logic        signed_q, offset_q, valid_q, err_q;
   logic [15:0] low_q;
   logic [31:0] result_q, fmt_d;
   logic [7:0]  byte_d;
   always_comb begin
      byte_d = offset_q ? mem_data_in[15:8] : mem_data_in[7:0];
      fmt_d  = (type_q == WT_HALF) ? (signed_q ? {{16{mem_data_in[15]}}, mem_data_in} : {16'h0, mem_data_in})
                                   : (signed_q ? {{24{byte_d[7]}}, byte_d} : {24'h0, byte_d});
   end
   // flush wins over both load_start (IDLE) and a same-cycle beat (BEAT0/BEAT1)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         type_q   <= 2'b00;
         signed_q <= 1'b0;
         offset_q <= 1'b0;
         low_q    <= 16'h0;
         result_q <= 32'h0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: if (!flush && load_start) begin
               if (word_type == WT_RSVD) err_q <= 1'b1;
               else begin
                  type_q   <= word_type;
                  signed_q <= is_signed;
                  offset_q <= byte_offset;
                  state_q  <= BEAT0;
               end
            end
            BEAT0: if (flush) state_q <= IDLE;
            else if (mem_data_valid) begin
               if (type_q == WT_WORD) begin
                  low_q   <= mem_data_in;
                  state_q <= BEAT1;
               end else begin
                  result_q <= fmt_d;
                  valid_q  <= 1'b1;
                  state_q  <= IDLE;
               end
            end
            BEAT1: if (flush) state_q <= IDLE;
            else if (mem_data_valid) begin
               result_q <= {mem_data_in, low_q};
               valid_q  <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign busy         = (state_q != IDLE);
   assign result_valid = valid_q;
   assign result       = result_q;
   assign type_error   = err_q;
endmodule

// File: tb/tb_load_data_formatter.sv
// tb_load_data_formatter: randomized and directed checks of load_data_formatter
// against a behavioural model of load formatting.
module tb_load_data_formatter;
   logic        clk = 1'b0, reset = 1'b1, load_start = 1'b0, is_signed = 1'b0, byte_offset = 1'b0;
   logic        flush = 1'b0, mem_data_valid = 1'b0;
   logic [1:0]  word_type = 2'b00;
   logic [15:0] mem_data_in = 16'h0;
   logic        busy, result_valid, type_error;
   logic [31:0] result, exp_res;
   int          n_checks = 0, n_fail = 0;

   load_data_formatter dut (
      .clk(clk), .reset(reset), .load_start(load_start), .word_type(word_type),
      .is_signed(is_signed), .byte_offset(byte_offset), .flush(flush),
      .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
      .busy(busy), .result_valid(result_valid), .result(result), .type_error(type_error)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [1:0] t, input logic s, input logic off,
                                         input logic [15:0] lo, input logic [15:0] hi);
      int v;
      if (t == 2'b10) return {hi, lo};
      if (t == 2'b01) begin
         v = int'(lo);
         if (s && v >= 32768) v = v - 65536;
         return 32'(v);
      end
      v = off ? int'(lo) / 256 : int'(lo) % 256;
      if (s && v >= 128) v = v - 256;
      return 32'(v);
   endfunction

   // Caller sits just after a negedge; returns at the negedge where result_valid should be high.
   task automatic do_load(input string name, input logic [1:0] t, input logic s, input logic off,
                          input logic [15:0] lo, input logic [15:0] hi, input int st0, input int st1);
      load_start = 1'b1; word_type = t; is_signed = s; byte_offset = off;
      @(negedge clk);
      load_start = 1'b0; word_type = $urandom_range(0, 3); is_signed = $urandom_range(0, 1);
      byte_offset = $urandom_range(0, 1);
      n_checks++;
      if (busy !== 1'b1 || result_valid !== 1'b0) begin
         n_fail++; $display("FAIL %s accept: busy=%b rv=%b want busy=1 rv=0", name, busy, result_valid);
      end
      for (int i = 0; i < st0; i++) begin
         mem_data_in = 16'($urandom); @(negedge clk);
         n_checks++;
         if (busy !== 1'b1 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s stall0: busy=%b rv=%b want 1/0", name, busy, result_valid);
         end
      end
      mem_data_valid = 1'b1; mem_data_in = lo;
      @(negedge clk);
      mem_data_valid = 1'b0;
      if (t == 2'b10) begin
         n_checks++;
         if (busy !== 1'b1 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s beat1 wait: busy=%b rv=%b want 1/0", name, busy, result_valid);
         end
         for (int i = 0; i < st1; i++) begin
            load_start = 1'b1; word_type = 2'b00;
            @(negedge clk);
            load_start = 1'b0;
            n_checks++;
            if (busy !== 1'b1 || result_valid !== 1'b0) begin
               n_fail++; $display("FAIL %s stall1: busy=%b rv=%b want 1/0", name, busy, result_valid);
            end
         end
         mem_data_valid = 1'b1; mem_data_in = hi;
         @(negedge clk);
         mem_data_valid = 1'b0;
      end
      exp_res = model(t, s, off, lo, hi);
      n_checks++;
      if (result_valid !== 1'b1 || result !== exp_res || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s result: rv=%b busy=%b result=%h want rv=1 busy=0 result=%h",
                  name, result_valid, busy, result, exp_res);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, result_valid, type_error} !== 3'b000 || result !== 32'h0) begin
         n_fail++; $display("FAIL reset_values: busy=%b rv=%b te=%b result=%h want all 0",
                            busy, result_valid, type_error, result);
      end
      reset = 1'b0;
      mem_data_valid = 1'b1; mem_data_in = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'h0) begin
            n_fail++; $display("FAIL idle_beat_ignored: busy=%b rv=%b result=%h want 0/0/0",
                               busy, result_valid, result);
         end
      end
      mem_data_valid = 1'b0;
      exp_res = 32'h0;
   endtask

   task automatic test_byte();
      do_load("byte_s_off1", 2'b00, 1'b1, 1'b1, 16'h80AB, 16'h0, 0, 0);
      do_load("byte_u_off1", 2'b00, 1'b0, 1'b1, 16'h80AB, 16'h0, 0, 0);
      do_load("byte_u_off0", 2'b00, 1'b0, 1'b0, 16'h80AB, 16'h0, 1, 0);
      do_load("byte_s_off0", 2'b00, 1'b1, 1'b0, 16'h80AB, 16'h0, 0, 0);
      @(negedge clk);
      n_checks++;
      if (result_valid !== 1'b0 || result !== exp_res) begin
         n_fail++; $display("FAIL byte_pulse_len: rv=%b result=%h want rv=0 result=%h", result_valid, result, exp_res);
      end
   endtask

   task automatic test_halfword();
      do_load("half_s", 2'b01, 1'b1, 1'b0, 16'h8001, 16'h0, 0, 0);
      do_load("half_u", 2'b01, 1'b0, 1'b1, 16'h8001, 16'h0, 0, 0);
      do_load("half_late", 2'b01, 1'b1, 1'b0, 16'h7FFE, 16'h0, 3, 0);
      @(negedge clk);
      n_checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL half_single_pulse: rv=%b busy=%b want 0/0", result_valid, busy);
      end
   endtask

   task automatic test_word();
      do_load("word_stall", 2'b10, 1'b0, 1'b0, 16'h5678, 16'h1234, 0, 2);
      @(negedge clk);
      n_checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h12345678) begin
         n_fail++; $display("FAIL word_after: rv=%b busy=%b result=%h want 0/0/12345678",
                            result_valid, busy, result);
      end
   endtask

   task automatic test_flush();
      load_start = 1'b1; word_type = 2'b10;
      @(negedge clk);
      load_start = 1'b0;
      mem_data_valid = 1'b1; mem_data_in = 16'hBEEF;
      @(negedge clk);
      flush = 1'b1; mem_data_in = 16'hDEAD;
      @(negedge clk);
      flush = 1'b0; mem_data_valid = 1'b0;
      n_checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
         n_fail++; $display("FAIL flush_beat1: rv=%b busy=%b result=%h want 0/0/%h",
                            result_valid, busy, result, exp_res);
      end
      flush = 1'b1; load_start = 1'b1; word_type = 2'b00;
      @(negedge clk);
      flush = 1'b0; load_start = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL flush_idle_drop: busy=%b want 0", busy);
      end
      do_load("after_flush", 2'b00, 1'b1, 1'b1, 16'hF00D, 16'h0, 0, 0);
   endtask

   task automatic test_type_error();
      load_start = 1'b1; word_type = 2'b11;
      @(negedge clk);
      load_start = 1'b0;
      n_checks++;
      if (type_error !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
         n_fail++; $display("FAIL type_error_pulse: te=%b busy=%b rv=%b want 1/0/0", type_error, busy, result_valid);
      end
      @(negedge clk);
      n_checks++;
      if (type_error !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL type_error_clear: te=%b busy=%b want 0/0", type_error, busy);
      end
   endtask

   task automatic test_async_reset();
      do_load("pre_reset", 2'b10, 1'b0, 1'b0, 16'h4321, 16'h8765, 0, 0);
      load_start = 1'b1; word_type = 2'b10;
      @(negedge clk);
      load_start = 1'b0; mem_data_valid = 1'b1; mem_data_in = 16'h1111;
      @(negedge clk);
      mem_data_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || result !== 32'h0 || result_valid !== 1'b0) begin
         n_fail++; $display("FAIL async_reset_clear: busy=%b result=%h rv=%b want 0/0/0", busy, result, result_valid);
      end
      @(negedge clk);
      reset = 1'b0; exp_res = 32'h0;
      mem_data_valid = 1'b1; mem_data_in = 16'h2222;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (result_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
            n_fail++; $display("FAIL post_reset_quiet: rv=%b busy=%b result=%h want 0/0/0", result_valid, busy, result);
         end
      end
      mem_data_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [1:0] t;
      for (int k = 0; k < 40; k++) begin
         t = 2'($urandom_range(0, 2));
         do_load("random", t, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                 $urandom_range(0, 2), $urandom_range(0, 2));
      end
      @(negedge clk);
      n_checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
         n_fail++; $display("FAIL b2b_tail: rv=%b busy=%b result=%h want 0/0/%h", result_valid, busy, result, exp_res);
      end
   endtask

   initial begin
      test_reset();
      test_byte();
      test_halfword();
      test_word();
      test_flush();
      test_type_error();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
